// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: instruction-fetch front end.
// Owns the PC, picks the next PC (pc+2, branch target or JR target), issues
// instruction memory reads and fills the IF/ID latch. A one-entry skid holds
// a fetched instruction while decode is stalled.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall                      hazard unit: freeze IF/ID this cycle
//   br_taken/br_addr           EX: taken conditional branch and its target
//   jr_taken/jr_addr           EX: register-indirect jump and its target
//   halt_id                    decode holds a valid HALT
//   imem_done/imem_rdata       imem: read data valid / fetched instruction
//   imem_rd/imem_addr          imem: read request / address (= pc)
//   ifid_instr/pc2/valid       IF/ID latch contents
//   halted                     fetch permanently stopped
module fetch_pc_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_addr,
  input  logic        jr_taken,
  input  logic [15:0] jr_addr,
  input  logic        halt_id,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  output logic        imem_rd,
  output logic [15:0] imem_addr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc2,
  output logic        ifid_valid,
  output logic        halted
);

  localparam int unsigned W = 16;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_HOLD   = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   pc_q, pc_d;
  logic [W-1:0]   pend_q, pend_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           halt_pend_q, halt_pend_d;
  logic [W-1:0]   ifid_instr_d, ifid_pc2_d;
  logic           ifid_valid_d;

  logic           redirect;
  logic [W-1:0]   target;
  logic [W-1:0]   pc_inc;
  logic           access_over;
  logic           halt_req;
  logic [W-1:0]   flush_tgt;

  assign redirect  = br_taken | jr_taken;
  assign target    = jr_taken ? jr_addr : br_addr;
  assign pc_inc    = pc_q + W'(2);
  // Nothing outstanding if the current access completes now, or if no
  // request was issued (first cycle after reset, or HOLD).
  assign access_over = imem_done | ~imem_rd;
  // A HALT seen while a read is in flight is remembered until it completes.
  assign halt_req  = (halt_id & ~stall) | halt_pend_q;
  assign flush_tgt = redirect ? target : pend_q;
  assign imem_addr = pc_q;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      skid_q      <= '0;
      halt_pend_q <= 1'b0;
      ifid_instr  <= NOP_INSTR;
      ifid_pc2    <= '0;
      ifid_valid  <= 1'b0;
      imem_rd     <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      skid_q      <= skid_d;
      halt_pend_q <= halt_pend_d;
      ifid_instr  <= ifid_instr_d;
      ifid_pc2    <= ifid_pc2_d;
      ifid_valid  <= ifid_valid_d;
      imem_rd     <= (state_d == S_FETCH) || (state_d == S_FLUSH);
      halted      <= (state_d == S_HALTED);
    end
  end

  // Next-state and next-PC selection.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    skid_d       = skid_q;
    halt_pend_d  = halt_pend_q;
    ifid_instr_d = ifid_instr;
    ifid_pc2_d   = ifid_pc2;
    ifid_valid_d = ifid_valid;

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          halt_pend_d  = 1'b0;
          if (access_over) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = S_FLUSH;
          end
        end else if (halt_req) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          if (access_over) begin
            halt_pend_d = 1'b0;
            state_d     = S_HALTED;
          end else begin
            halt_pend_d = 1'b1;
          end
        end else if (imem_done && imem_rd) begin
          pc_d = pc_inc;
          if (!stall) begin
            ifid_instr_d = imem_rdata;
            ifid_pc2_d   = pc_inc;
            ifid_valid_d = 1'b1;
          end else begin
            skid_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end else if (!stall) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        // The skid entry's pc+2 equals the current pc.
        if (redirect) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          pc_d         = target;
          state_d      = S_FETCH;
        end else if (halt_id && !stall) begin
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          state_d      = S_HALTED;
        end else if (!stall) begin
          ifid_instr_d = skid_q;
          ifid_pc2_d   = pc_q;
          ifid_valid_d = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_FLUSH: begin
        // Wrong-path access still in flight: bubble until it returns.
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
        pend_d       = flush_tgt;
        if (imem_done) begin
          pc_d    = flush_tgt;
          state_d = S_FETCH;
        end
      end

      S_HALTED: begin
        state_d = S_HALTED;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: sequential fetch, slow memory, stall/skid,
// redirect flush, JR priority, PC wrap, halt and async reset.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_addr;
  logic        jr_taken;
  logic [15:0] jr_addr;
  logic        halt_id;
  logic        imem_done;
  logic [15:0] imem_rdata;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc2;
  logic        ifid_valid;
  logic        halted;

  int total = 0;
  int bad   = 0;

  fetch_pc_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .jr_taken   (jr_taken),
    .jr_addr    (jr_addr),
    .halt_id    (halt_id),
    .imem_done  (imem_done),
    .imem_rdata (imem_rdata),
    .imem_rd    (imem_rd),
    .imem_addr  (imem_addr),
    .ifid_instr (ifid_instr),
    .ifid_pc2   (ifid_pc2),
    .ifid_valid (ifid_valid),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, then sample 1 time unit after the edge.
  task automatic cyc(input logic d, input logic [15:0] rdata,
                     input logic br, input logic [15:0] ba,
                     input logic jr, input logic [15:0] ja,
                     input logic h, input logic s);
    imem_done  = d;
    imem_rdata = rdata;
    br_taken   = br;
    br_addr    = ba;
    jr_taken   = jr;
    jr_addr    = ja;
    halt_id    = h;
    stall      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rd"},    16'(imem_rd),    16'h0);
    chk({tag, "_addr"},  imem_addr,       16'h0000);
    chk({tag, "_instr"}, ifid_instr,      16'h0800);
    chk({tag, "_pc2"},   ifid_pc2,        16'h0000);
    chk({tag, "_valid"}, 16'(ifid_valid), 16'h0);
    chk({tag, "_halt"},  16'(halted),     16'h0);
  endtask

  initial begin
    rst_n = 1'b1;
    stall = 0; br_taken = 0; br_addr = '0; jr_taken = 0; jr_addr = '0;
    halt_id = 0; imem_done = 0; imem_rdata = '0;
    #2 rst_n = 1'b0;
    #1 chk_reset("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First edge out of reset: request raised at RESET_PC.
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("start_rd",   16'(imem_rd), 16'h1);
    chk("start_addr", imem_addr,    16'h0000);
    chk("start_val",  16'(ifid_valid), 16'h0);

    // Back-to-back fetches.
    cyc(1, 16'h1000, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("seq0_addr",  imem_addr,  16'h0002);
    chk("seq0_instr", ifid_instr, 16'h1000);
    chk("seq0_pc2",   ifid_pc2,   16'h0002);
    chk("seq0_val",   16'(ifid_valid), 16'h1);
    cyc(1, 16'h1002, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("seq1_addr",  imem_addr, 16'h0004);
    chk("seq1_pc2",   ifid_pc2,  16'h0004);
    cyc(1, 16'h1004, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("seq2_addr",  imem_addr,  16'h0006);
    chk("seq2_pc2",   ifid_pc2,   16'h0006);
    chk("seq2_instr", ifid_instr, 16'h1004);

    // Redirect to 4 with data returning: immediate, bubble.
    cyc(1, 16'hBEEF, 1, 16'h0004, 0, 16'h0, 0, 0);
    chk("redir4_addr", imem_addr,  16'h0004);
    chk("redir4_val",  16'(ifid_valid), 16'h0);
    chk("redir4_ins",  ifid_instr, 16'h0800);

    // Slow memory: three wait cycles at pc=4.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0);
      chk($sformatf("wait%0d_addr", i), imem_addr, 16'h0004);
      chk($sformatf("wait%0d_val", i),  16'(ifid_valid), 16'h0);
    end
    cyc(1, 16'h1234, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("late_instr", ifid_instr, 16'h1234);
    chk("late_pc2",   ifid_pc2,   16'h0006);
    chk("late_addr",  imem_addr,  16'h0006);

    // Stall as data arrives at pc=8: skid captures, IF/ID frozen.
    cyc(1, 16'h0, 1, 16'h0008, 0, 16'h0, 0, 0);
    chk("to8_addr", imem_addr, 16'h0008);
    cyc(1, 16'h5678, 0, 16'h0, 0, 16'h0, 0, 1);
    chk("hold0_rd",   16'(imem_rd), 16'h0);
    chk("hold0_addr", imem_addr,    16'h000A);
    chk("hold0_ins",  ifid_instr,   16'h0800);
    chk("hold0_val",  16'(ifid_valid), 16'h0);
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 1);
    chk("hold1_rd",   16'(imem_rd), 16'h0);
    chk("hold1_ins",  ifid_instr,   16'h0800);
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("rel_ins",  ifid_instr, 16'h5678);
    chk("rel_pc2",  ifid_pc2,   16'h000A);
    chk("rel_val",  16'(ifid_valid), 16'h1);
    chk("rel_rd",   16'(imem_rd), 16'h1);
    chk("rel_addr", imem_addr,  16'h000A);

    // Branch while access pending at 0x10: flush, returned data dropped.
    cyc(1, 16'h0, 1, 16'h0010, 0, 16'h0, 0, 0);
    chk("to10_addr", imem_addr, 16'h0010);
    cyc(0, 16'h0, 1, 16'h0040, 0, 16'h0, 0, 0);
    chk("fl_addr", imem_addr,    16'h0010);
    chk("fl_rd",   16'(imem_rd), 16'h1);
    chk("fl_val",  16'(ifid_valid), 16'h0);
    cyc(1, 16'hDEAD, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("fl_done_addr", imem_addr,  16'h0040);
    chk("fl_done_ins",  ifid_instr, 16'h0800);
    chk("fl_done_val",  16'(ifid_valid), 16'h0);

    // Branch and JR together: JR wins.
    cyc(0, 16'h0, 1, 16'h0040, 1, 16'h0080, 0, 0);
    chk("jr_pend_addr", imem_addr, 16'h0040);
    cyc(1, 16'hDEAD, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("jr_addr", imem_addr, 16'h0080);

    // PC wrap.
    cyc(1, 16'h0, 1, 16'hFFFE, 0, 16'h0, 0, 0);
    chk("toFFFE_addr", imem_addr, 16'hFFFE);
    cyc(1, 16'h7777, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("wrap_pc2",  ifid_pc2,   16'h0000);
    chk("wrap_addr", imem_addr,  16'h0000);
    chk("wrap_ins",  ifid_instr, 16'h7777);

    // HALT with branch in the same cycle: branch wins.
    cyc(1, 16'h0, 1, 16'h0020, 0, 16'h0, 1, 0);
    chk("hb_halt", 16'(halted),  16'h0);
    chk("hb_addr", imem_addr,    16'h0020);
    chk("hb_rd",   16'(imem_rd), 16'h1);

    // HALT while access pending: halts once it completes.
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 1, 0);
    chk("hp_halt", 16'(halted),  16'h0);
    chk("hp_rd",   16'(imem_rd), 16'h1);
    cyc(1, 16'h9999, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("h_halt", 16'(halted),  16'h1);
    chk("h_rd",   16'(imem_rd), 16'h0);
    chk("h_addr", imem_addr,    16'h0020);
    chk("h_ins",  ifid_instr,   16'h0800);
    cyc(1, 16'h0, 1, 16'h0040, 0, 16'h0, 0, 0);
    chk("h_stay",   16'(halted), 16'h1);
    chk("h_frozen", imem_addr,   16'h0020);

    // Async reset in the middle of an outstanding access.
    rst_n = 1'b0;
    #1 chk_reset("rst2");
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0);
    cyc(1, 16'h2222, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("r_pc2", ifid_pc2, 16'h0002);
    cyc(0, 16'h0, 0, 16'h0, 0, 16'h0, 0, 0);
    chk("r_addr", imem_addr, 16'h0002);
    rst_n = 1'b0;
    #1 chk_reset("rst3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
